// File: rtl/conv_controller.sv
// Sequencing controller for a systolic convolution array: loads filter and
// ifmap beats, runs NUM_PASSES conv passes with a one-beat window shift between them.
module conv_controller #(
  parameter int FILT_LEN   = 3,
  parameter int IFMAP_LEN  = 5,
  parameter int CONV_LEN   = 3,
  parameter int NUM_PASSES = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              read_new_filter_val,
  output logic                              read_new_ifmap_val,
  output logic                              start_conv,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_PASSES+1)-1:0]   pass_idx
);

  localparam int MAX_LEN = (FILT_LEN > IFMAP_LEN)
                         ? ((FILT_LEN  > CONV_LEN) ? FILT_LEN  : CONV_LEN)
                         : ((IFMAP_LEN > CONV_LEN) ? IFMAP_LEN : CONV_LEN);
  localparam int CNT_W  = $clog2(MAX_LEN) + 1;
  localparam int PASS_W = $clog2(NUM_PASSES + 1);

  localparam logic [CNT_W-1:0]  FILT_LAST  = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]  IFMAP_LAST = CNT_W'(IFMAP_LEN - 1);
  localparam logic [CNT_W-1:0]  CONV_LAST  = CNT_W'(CONV_LEN - 1);
  localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILTER,
    LOAD_IFMAP,
    SHIFT_IFMAP,
    CONV,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              in_ready_q, in_ready_d;
  logic              start_conv_q, start_conv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  // A beat is consumed only while the registered ready is high.
  assign accept = in_valid & in_ready_q;

  // NOTE: every signal assigned in always_comb gets a default up front so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_FILTER;
          pass_d  = '0;
        end
      end
      LOAD_FILTER: begin
        if (accept) begin
          if (cnt_q == FILT_LAST) state_d = LOAD_IFMAP;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      LOAD_IFMAP: begin
        if (accept) begin
          if (cnt_q == IFMAP_LAST) state_d = CONV;
          else                     cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      SHIFT_IFMAP: begin
        if (accept) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          if (pass_q == PASS_LAST) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT_IFMAP;
            pass_d  = pass_q + PASS_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        pass_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a start seen in IDLE.
    if (clear) begin
      state_d = IDLE;
      pass_d  = '0;
    end

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they register alongside it.
    in_ready_d   = (state_d == LOAD_FILTER) || (state_d == LOAD_IFMAP) ||
                   (state_d == SHIFT_IFMAP);
    start_conv_d = (state_d == CONV);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pass_q       <= '0;
      in_ready_q   <= 1'b0;
      start_conv_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      in_ready_q   <= in_ready_d;
      start_conv_q <= start_conv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready            = in_ready_q;
  assign read_new_filter_val = accept & (state_q == LOAD_FILTER);
  assign read_new_ifmap_val  = accept & ((state_q == LOAD_IFMAP) ||
                                         (state_q == SHIFT_IFMAP));
  assign start_conv          = start_conv_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign pass_idx            = pass_q;

endmodule

// File: tb/tb_conv_controller.sv
// Self-checking bench for conv_controller: directed scenarios plus random
// start/clear/in_valid traffic against a queue-of-steps job model.
module tb_conv_controller;

  localparam int FL = 3;
  localparam int IL = 5;
  localparam int CL = 3;
  localparam int NP = 3;
  localparam int PW = $clog2(NP + 1);

  logic          clk = 1'b0;
  logic          rst_n, start, clear, in_valid;
  logic          in_ready, rf, ri, sc, busy, done;
  logic [PW-1:0] pass_idx;

  logic          start1, in_valid1;
  logic          ir1, rf1, ri1, sc1, busy1, done1;
  logic [0:0]    pass1;

  always #5 clk = ~clk;

  conv_controller #(.FILT_LEN(FL), .IFMAP_LEN(IL), .CONV_LEN(CL), .NUM_PASSES(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .read_new_filter_val(rf), .read_new_ifmap_val(ri),
    .start_conv(sc), .busy(busy), .done(done), .pass_idx(pass_idx)
  );

  conv_controller #(.FILT_LEN(FL), .IFMAP_LEN(IL), .CONV_LEN(1), .NUM_PASSES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clear(1'b0), .in_valid(in_valid1),
    .in_ready(ir1), .read_new_filter_val(rf1), .read_new_ifmap_val(ri1),
    .start_conv(sc1), .busy(busy1), .done(done1), .pass_idx(pass1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Job model: the whole job is a list of steps; beat steps advance only when
  // in_valid is high, conv and done steps advance every cycle.
  typedef enum {S_F, S_I, S_C, S_D} step_e;
  typedef struct {
    step_e kind;
    int    pass;
  } step_t;

  step_t q[$];
  int    cyc       = 0;
  int    last_done = -1;
  int    done_cnt  = 0;
  int    t0;

  function automatic void load_job();
    for (int i = 0; i < FL; i++) q.push_back('{S_F, 0});
    for (int i = 0; i < IL; i++) q.push_back('{S_I, 0});
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < CL; i++) q.push_back('{S_C, p});
      if (p < NP - 1) q.push_back('{S_I, p + 1});
    end
    q.push_back('{S_D, NP - 1});
  endfunction

  task automatic compare(input logic v);
    logic e_ir, e_rf, e_ri, e_sc, e_busy, e_done;
    int   e_pass;
    e_ir = 0; e_rf = 0; e_ri = 0; e_sc = 0; e_busy = 0; e_done = 0; e_pass = 0;
    if (q.size() != 0) begin
      e_busy = 1;
      e_pass = q[0].pass;
      case (q[0].kind)
        S_F: begin e_ir = 1; e_rf = v; end
        S_I: begin e_ir = 1; e_ri = v; end
        S_C: e_sc = 1;
        S_D: e_done = 1;
        default: ;
      endcase
    end
    check("in_ready", 32'(in_ready), 32'(e_ir));
    check("filter_val", 32'(rf), 32'(e_rf));
    check("ifmap_val", 32'(ri), 32'(e_ri));
    check("start_conv", 32'(sc), 32'(e_sc));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    if (q.size() != 0) check("pass_idx", 32'(pass_idx), 32'(e_pass));
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model.
  task automatic cycle(input logic s, input logic c, input logic v);
    start = s; clear = c; in_valid = v;
    @(negedge clk);
    compare(v);
    if (done) begin
      last_done = cyc;
      done_cnt++;
    end
    if (c) q.delete();
    else if (q.size() == 0) begin
      if (s) load_job();
    end else if (q[0].kind == S_F || q[0].kind == S_I) begin
      if (v) void'(q.pop_front());
    end else begin
      void'(q.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  int sc1_n, ri1_n, rf1_n, sc1_last, d1_cyc;

  initial begin
    rst_n = 1'b0; start = 0; clear = 0; in_valid = 0; start1 = 0; in_valid1 = 0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_pass", 32'(pass_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(0, 0, 1);

    // Baseline job, in_valid always high: done 20 cycles after start.
    t0 = cyc;
    cycle(1, 0, 1);
    repeat (24) cycle(0, 0, 1);
    check("base_done_cyc", 32'(last_done - t0), 20);

    // in_valid low for cycles 2-4 delays everything by three.
    t0 = cyc;
    cycle(1, 0, 1);
    cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);
    repeat (22) cycle(0, 0, 1);
    check("stall_done_cyc", 32'(last_done - t0), 23);

    // A second start mid-job is ignored.
    t0 = cyc; done_cnt = 0;
    for (int i = 0; i < 26; i++) cycle(i == 0 || i == 10, 0, 1);
    check("restart_done_n", 32'(done_cnt), 1);
    check("restart_done_cyc", 32'(last_done - t0), 20);

    // clear + start during the second pass aborts; then a full job runs.
    t0 = cyc;
    for (int i = 0; i < 14; i++) cycle(i == 0, 0, 1);
    check("pre_clr_pass", 32'(pass_idx), 1);
    cycle(1, 1, 1);
    check("clr_busy", 32'(busy), 0);
    check("clr_pass", 32'(pass_idx), 0);
    cycle(0, 0, 1);
    t0 = cyc;
    cycle(1, 0, 1);
    repeat (24) cycle(0, 0, 1);
    check("post_clr_done_cyc", 32'(last_done - t0), 20);

    // clear while in DONE still shows the done pulse that cycle.
    t0 = cyc;
    for (int i = 0; i < 23; i++) cycle(i == 0, i == 20, 1);
    check("clr_done_cyc", 32'(last_done - t0), 20);

    // Asynchronous reset in the middle of LOAD_IFMAP.
    cycle(1, 0, 1);
    repeat (5) cycle(0, 0, 1);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(in_ready), 0);
    check("arst_ifmap", 32'(ri), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_pass", 32'(pass_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    repeat (5) cycle(0, 0, 1);
    check("post_rst_idle", 32'(busy), 0);

    // Single pass, single conv cycle: no shift beat, done right after conv.
    sc1_n = 0; ri1_n = 0; rf1_n = 0; sc1_last = -1; d1_cyc = -1;
    for (int i = 0; i < 15; i++) begin
      start1 = (i == 0); in_valid1 = 1'b1;
      @(negedge clk);
      if (sc1) begin sc1_n++; sc1_last = i; end
      if (ri1) ri1_n++;
      if (rf1) rf1_n++;
      if (done1) d1_cyc = i;
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    check("p1_conv_n", 32'(sc1_n), 1);
    check("p1_ifmap_n", 32'(ri1_n), IL);
    check("p1_filter_n", 32'(rf1_n), FL);
    check("p1_conv_cyc", 32'(sc1_last), 9);
    check("p1_done_cyc", 32'(d1_cyc), 10);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
